// File: rtl/vip_edge_pipe.sv
// RGB565 video pipeline: bypass, grayscale, Sobel binary edge or Sobel magnitude.
// Fixed 8-cycle latency on sync, enable and pixel data, independent of the selected mode.
module vip_edge_pipe #(
  parameter int IMG_W_MAX      = 1024,
  parameter int DATA_W         = 8,
  parameter int THRESH_DEFAULT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_hsync,
  input  logic              pre_frame_de,
  input  logic [15:0]       pre_rgb,
  output logic              post_frame_vsync,
  output logic              post_frame_hsync,
  output logic              post_frame_de,
  output logic [15:0]       post_rgb,
  output logic              line_ovf
);

  localparam int AW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
  localparam int CW = $clog2(IMG_W_MAX + 1) + 1;
  localparam int RW = 12;
  localparam int GW = DATA_W + 3;
  localparam logic [CW-1:0] COL_LIM = CW'(IMG_W_MAX);
  localparam logic [GW:0]   MAG_MAX = (GW+1)'({DATA_W{1'b1}});

  typedef struct packed {
    logic              vs;
    logic              hs;
    logic              de;
    logic [15:0]       rgb;
    logic [1:0]        md;
    logic [DATA_W-1:0] thr;
    logic              edge_mask;
    logic              wr;
    logic [AW-1:0]     addr;
  } ctl_t;

  logic              vsync_q, de_q, frame_start;
  logic [CW-1:0]     col_cnt, col_cur;
  logic [RW-1:0]     row_cnt, row_cur;
  logic [1:0]        active_mode;
  logic [DATA_W-1:0] active_thr;
  logic              in_ovf;
  ctl_t              ctl_in;
  ctl_t              ctl [1:7];

  // A pixel arriving with the frame start already belongs to the new frame.
  always_comb begin
    frame_start = pre_frame_vsync & ~vsync_q;
    col_cur     = frame_start ? '0 : col_cnt;
    row_cur     = frame_start ? '0 : row_cnt;
    in_ovf      = pre_frame_de && (col_cur >= COL_LIM);
    ctl_in           = '0;
    ctl_in.vs        = pre_frame_vsync;
    ctl_in.hs        = pre_frame_hsync;
    ctl_in.de        = pre_frame_de;
    ctl_in.rgb       = pre_rgb;
    ctl_in.md        = frame_start ? mode : active_mode;
    ctl_in.thr       = frame_start ? threshold : active_thr;
    ctl_in.edge_mask = (row_cur < RW'(2)) || (col_cur < CW'(2)) || (col_cur >= COL_LIM);
    ctl_in.wr        = pre_frame_de && (col_cur < COL_LIM);
    ctl_in.addr      = col_cur[AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      active_mode <= 2'd0;
      active_thr  <= DATA_W'(THRESH_DEFAULT);
      line_ovf    <= 1'b0;
    end else begin
      vsync_q <= pre_frame_vsync;
      de_q    <= pre_frame_de;
      if (frame_start) begin
        active_mode <= mode;
        active_thr  <= threshold;
      end
      if (!pre_frame_de)
        col_cnt <= '0;
      else if (col_cur != '1)
        col_cnt <= col_cur + 1'b1;
      else
        col_cnt <= col_cur;
      if (frame_start)
        row_cnt <= '0;
      else if (de_q && !pre_frame_de && row_cnt != '1)
        row_cnt <= row_cnt + 1'b1;
      if (frame_start)
        line_ovf <= 1'b0;
      else if (in_ovf)
        line_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 7; i++) ctl[i] <= '0;
    end else begin
      ctl[1] <= ctl_in;
      for (int i = 2; i <= 7; i++) ctl[i] <= ctl[i-1];
    end
  end

  // Gray conversion: weighted products, 16-bit sum, then the top byte.
  logic [7:0]        r8, g8, b8;
  logic [15:0]       pr_r, pr_g, pr_b, sum_q;
  logic [DATA_W-1:0] y_p [3:7];

  always_comb begin
    r8 = {pre_rgb[15:11], pre_rgb[15:13]};
    g8 = {pre_rgb[10:5], pre_rgb[10:9]};
    b8 = {pre_rgb[4:0], pre_rgb[4:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_r  <= '0;
      pr_g  <= '0;
      pr_b  <= '0;
      sum_q <= '0;
      for (int i = 3; i <= 7; i++) y_p[i] <= '0;
    end else begin
      pr_r   <= 16'(r8) * 16'd77;
      pr_g   <= 16'(g8) * 16'd150;
      pr_b   <= 16'(b8) * 16'd29;
      sum_q  <= pr_r + pr_g + pr_b;
      y_p[3] <= DATA_W'(sum_q >> 8);
      for (int i = 4; i <= 7; i++) y_p[i] <= y_p[i-1];
    end
  end

  // Cascaded line buffers: lb0 holds row y-1, lb1 receives what lb0 held (row y-2).
  logic [DATA_W-1:0] lb0 [IMG_W_MAX];
  logic [DATA_W-1:0] lb1 [IMG_W_MAX];
  logic [DATA_W-1:0] rd0, rd1;

  always_ff @(posedge clk) begin
    rd0 <= lb0[ctl[3].addr];
    rd1 <= lb1[ctl[3].addr];
    if (ctl[3].wr) lb0[ctl[3].addr] <= y_p[3];
    if (ctl[4].wr) lb1[ctl[4].addr] <= rd0;
  end

  logic [DATA_W-1:0] win [3][3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (ctl[4].de) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= rd1;
      win[1][2] <= rd0;
      win[2][2] <= y_p[4];
    end
  end

  logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx_c, gy_c;
  logic [GW-1:0] gx, gy, ax, ay;
  logic [GW:0]   abs_sum;
  logic [DATA_W-1:0] mag;

  always_comb begin
    gx_pos  = GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]);
    gx_neg  = GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]);
    gy_pos  = GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]);
    gy_neg  = GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]);
    gx_c    = gx_pos - gx_neg;
    gy_c    = gy_pos - gy_neg;
    ax      = gx[GW-1] ? (~gx + 1'b1) : gx;
    ay      = gy[GW-1] ? (~gy + 1'b1) : gy;
    abs_sum = {1'b0, ax} + {1'b0, ay};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx  <= '0;
      gy  <= '0;
      mag <= '0;
    end else begin
      gx  <= gx_c;
      gy  <= gy_c;
      mag <= (abs_sum > MAG_MAX) ? {DATA_W{1'b1}} : abs_sum[DATA_W-1:0];
    end
  end

  logic [15:0] sel;

  always_comb begin
    sel = 16'h0000;
    case (ctl[7].md)
      2'd0: sel = ctl[7].rgb;
      2'd1: sel = {y_p[7][7:3], y_p[7][7:2], y_p[7][7:3]};
      2'd2: sel = (mag > ctl[7].thr) ? 16'hFFFF : 16'h0000;
      2'd3: sel = {mag[7:3], mag[7:2], mag[7:3]};
      default: sel = 16'h0000;
    endcase
    if (ctl[7].md[1] && ctl[7].edge_mask) sel = 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_de    <= 1'b0;
      post_rgb         <= 16'h0000;
    end else begin
      post_frame_vsync <= ctl[7].vs;
      post_frame_hsync <= ctl[7].hs;
      post_frame_de    <= ctl[7].de;
      post_rgb         <= ctl[7].de ? sel : 16'h0000;
    end
  end

endmodule

// File: tb/tb_vip_edge_pipe.sv
// Randomised bench for vip_edge_pipe against a frame-level reference model.
// The model keeps the current frame's gray image and evaluates the Sobel window directly.
module tb_vip_edge_pipe;

  localparam int WMAX = 16;

  logic        clk, rst;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
  logic [15:0] pre_rgb;
  logic        post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [15:0] post_rgb;
  logic        line_ovf;

  vip_edge_pipe #(.IMG_W_MAX(WMAX), .DATA_W(8), .THRESH_DEFAULT(128)) dut (
    .clk(clk), .rst(rst), .mode(mode), .threshold(threshold),
    .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
    .pre_frame_de(pre_frame_de), .pre_rgb(pre_rgb),
    .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
    .post_frame_de(post_frame_de), .post_rgb(post_rgb), .line_ovf(line_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sync;
    logic [15:0] rgb;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;
  int   img [0:7][0:31];
  int   f_mode = 0, f_thr = 128;
  logic m_ovf = 1'b0, m_vs_prev = 1'b0;

  localparam int PAT_RAMP = 0, PAT_CONST = 1, PAT_EDGE = 2, PAT_RAND = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int y_of(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p) / 2048;
    g6 = (int'(p) / 32) % 64;
    b5 = int'(p) % 32;
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  function automatic logic [15:0] pack(input int v);
    return 16'((v / 8) * 2048 + (v / 4) * 32 + v / 8);
  endfunction

  function automatic logic [15:0] exp_pix(input int md, input int th, input int row,
                                          input int col, input logic [15:0] rgb);
    int gx, gy, mag;
    if (md == 0) return rgb;
    if (md == 1) return pack(y_of(rgb));
    if (row < 2 || col < 2 || col >= WMAX) return 16'h0000;
    gx = (img[row-2][col] + 2 * img[row-1][col] + img[row][col])
       - (img[row-2][col-2] + 2 * img[row-1][col-2] + img[row][col-2]);
    gy = (img[row][col-2] + 2 * img[row][col-1] + img[row][col])
       - (img[row-2][col-2] + 2 * img[row-2][col-1] + img[row-2][col]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (md == 2) return (mag > th) ? 16'hFFFF : 16'h0000;
    return pack(mag);
  endfunction

  // One input cycle: check what the DUT shows now, then drive and predict 8 cycles ahead.
  task automatic tick(input logic vs, input logic hs, input logic de,
                      input logic [15:0] rgb, input int row, input int col);
    exp_t e;
    @(negedge clk);
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    check("sync", {29'd0, post_frame_vsync, post_frame_hsync, post_frame_de}, {29'd0, e.sync});
    check("rgb", {16'd0, post_rgb}, {16'd0, e.rgb});
    check("line_ovf", {31'd0, line_ovf}, {31'd0, m_ovf});
    pre_frame_vsync = vs;
    pre_frame_hsync = hs;
    pre_frame_de    = de;
    pre_rgb         = rgb;
    if (vs && !m_vs_prev) begin
      f_mode = int'(mode);
      f_thr  = int'(threshold);
      m_ovf  = 1'b0;
    end
    m_vs_prev = vs;
    e.sync = {vs, hs, de};
    e.rgb  = 16'h0000;
    if (de) begin
      if (row < 8 && col < 32) img[row][col] = y_of(rgb);
      e.rgb = exp_pix(f_mode, f_thr, row, col, rgb);
      if (col >= WMAX) m_ovf = 1'b1;
    end
    q.push_back(e);
  endtask

  function automatic logic [15:0] pix(input int pat, input logic [15:0] pv, input int col);
    case (pat)
      PAT_RAMP:  return 16'(col);
      PAT_CONST: return pv;
      PAT_EDGE:  return (col < 8) ? 16'h0000 : 16'hFFFF;
      default:   return 16'($urandom);
    endcase
  endfunction

  task automatic run_frame(input int md, input int th, input int nlines, input int width,
                           input int pat, input logic [15:0] pv, input bit chg);
    int g;
    mode      = 2'(md);
    threshold = 8'(th);
    tick(1, 0, 0, 16'h0, 0, 0);
    tick(1, 0, 0, 16'h0, 0, 0);
    tick(0, 0, 0, 16'h0, 0, 0);
    for (int l = 0; l < nlines; l++) begin
      g = (l == 0) ? 3 : int'($urandom_range(1, 3));
      for (int k = 0; k < g; k++) tick(0, k == g - 1, 0, 16'h0, 0, 0);
      for (int c = 0; c < width; c++) tick(0, 0, 1, pix(pat, pv, c), l, c);
      if (chg && l == 0) begin
        mode      = 2'd3;
        threshold = 8'd10;
      end
    end
    for (int k = 0; k < 12; k++) tick(0, 0, 0, 16'h0, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back('0);
    m_ovf = 1'b0;
    m_vs_prev = 1'b0;
    f_mode = 0;
    f_thr = 128;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vsync"}, {31'd0, post_frame_vsync}, 32'd0);
    check({tag, "_hsync"}, {31'd0, post_frame_hsync}, 32'd0);
    check({tag, "_de"}, {31'd0, post_frame_de}, 32'd0);
    check({tag, "_rgb"}, {16'd0, post_rgb}, 32'd0);
    check({tag, "_ovf"}, {31'd0, line_ovf}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    threshold = 8'd128;
    pre_frame_vsync = 1'b0;
    pre_frame_hsync = 1'b0;
    pre_frame_de = 1'b0;
    pre_rgb = 16'h0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 32; c++) img[r][c] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick(0, 0, 0, 16'h0, 0, 0);

    run_frame(0, 128, 2, 640, PAT_RAMP, 16'h0, 0);
    run_frame(1, 128, 2, 8, PAT_CONST, 16'hF800, 0);
    run_frame(1, 128, 2, 8, PAT_CONST, 16'hFFFF, 0);
    run_frame(2, 128, 4, 16, PAT_EDGE, 16'h0, 1);
    run_frame(3, 10, 4, 16, PAT_CONST, 16'h7BEF, 0);
    run_frame(3, 0, 5, 16, PAT_RAND, 16'h0, 0);
    run_frame(2, int'($urandom_range(0, 255)), 5, 14, PAT_RAND, 16'h0, 0);
    run_frame(1, 128, 3, 12, PAT_RAND, 16'h0, 0);
    run_frame(2, 128, 4, 20, PAT_EDGE, 16'h0, 0);
    run_frame(2, 128, 3, 16, PAT_RAND, 16'h0, 0);

    // Asynchronous reset in the middle of a bypass line that has already overflowed.
    mode = 2'd0;
    tick(1, 0, 0, 16'h0, 0, 0);
    tick(0, 0, 0, 16'h0, 0, 0);
    for (int c = 0; c < 20; c++) tick(0, 0, 1, 16'(c + 1), 0, c);
    #2;
    rst = 1'b1;
    pre_frame_vsync = 1'b0;
    pre_frame_hsync = 1'b0;
    pre_frame_de = 1'b0;
    pre_rgb = 16'h0;
    #1;
    check_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      check_zero("rst_hold");
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) tick(0, 0, 0, 16'h0, 0, 0);
    run_frame(3, 40, 4, 16, PAT_RAND, 16'h0, 0);
    run_frame(2, 128, 4, 16, PAT_EDGE, 16'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
